// File: rtl/siren_pattern_sequencer.sv
// Siren pattern sequencer. Drives WIDTH lamp/buzzer lines in one of four
// patterns: alternate, chase, bounce or flash. The pattern advances one step
// per tick_enable pulse. An optional burst length stops the run after that
// many steps and reports completion until enable_siren is dropped.
module siren_pattern_sequencer #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tick_enable,
  input  logic             enable_siren,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] burst_len,
  output logic [WIDTH-1:0] siren,
  output logic             active,
  output logic             done
);

  // Wide enough to hold every phase of the longest pattern (bounce, 2N-2).
  localparam int PH_W = $clog2(2 * WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [PH_W-1:0]  phase;
  logic [CNT_W-1:0] step;
  logic [1:0]       mode_lat;
  logic [CNT_W-1:0] burst_lat;

  // Last phase index of each pattern; the phase wraps to 0 after it.
  function automatic logic [PH_W-1:0] phase_last(input logic [1:0] m);
    logic [PH_W-1:0] last;
    case (m)
      2'd1:    last = PH_W'(WIDTH - 1);
      2'd2:    last = PH_W'(2 * WIDTH - 3);
      default: last = PH_W'(1);
    endcase
    return last;
  endfunction

  // Line image for a given pattern and phase; bit 0 is the first lamp.
  function automatic logic [WIDTH-1:0] pattern(input logic [1:0] m,
                                               input logic [PH_W-1:0] ph);
    logic [WIDTH-1:0] one;
    logic [WIDTH-1:0] pat;
    one = WIDTH'(1);
    case (m)
      2'd0:    pat = (ph == '0) ? one : (one << (WIDTH - 1));
      2'd1:    pat = one << ph;
      // Bounce walks up to the top lamp and back down without repeating
      // either end lamp, so phases above N-1 mirror back as (2N-2)-phase.
      2'd2:    pat = (int'(ph) < WIDTH) ? (one << ph)
                                        : (one << (PH_W'(2 * WIDTH - 2) - ph));
      default: pat = (ph == '0) ? '1 : '0;
    endcase
    return pat;
  endfunction

  // Run/stop control, pattern stepping and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      phase     <= '0;
      step      <= '0;
      mode_lat  <= '0;
      burst_lat <= '0;
      siren     <= '0;
      active    <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          siren <= '0;
          // A tick on the start edge is deliberately ignored: the first
          // pattern step appears on the following tick.
          if (enable_siren) begin
            state     <= ST_RUN;
            active    <= 1'b1;
            done      <= 1'b0;
            mode_lat  <= mode;
            burst_lat <= burst_len;
            phase     <= '0;
            step      <= '0;
          end
        end

        ST_RUN: begin
          // Dropping enable wins over a coincident tick.
          if (!enable_siren) begin
            state  <= ST_IDLE;
            active <= 1'b0;
            siren  <= '0;
          end else if (tick_enable) begin
            if ((burst_lat != '0) && (step == burst_lat)) begin
              state  <= ST_DONE;
              active <= 1'b0;
              done   <= 1'b1;
              siren  <= '0;
            end else begin
              siren <= pattern(mode_lat, phase);
              phase <= (phase == phase_last(mode_lat)) ? '0 : phase + 1'b1;
              if (step != '1) begin
                step <= step + 1'b1;
              end
            end
          end
        end

        ST_DONE: begin
          siren <= '0;
          // Re-arming needs enable low first; a held enable keeps us here.
          if (!enable_siren) begin
            state <= ST_IDLE;
            done  <= 1'b0;
          end
        end

        default: begin
          state  <= ST_IDLE;
          siren  <= '0;
          active <= 1'b0;
          done   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_siren_pattern_sequencer.sv
// Testbench for siren_pattern_sequencer: a 3-line and a 5-line instance share
// all inputs and are checked against a step-count based behavioural model.
module tb_siren_pattern_sequencer;

  logic       clock;
  logic       reset;
  logic       tick_enable;
  logic       enable_siren;
  logic [1:0] mode;
  logic [7:0] burst_len;

  logic [2:0] siren3;
  logic       active3;
  logic       done3;
  logic [4:0] siren5;
  logic       active5;
  logic       done5;

  int checks;
  int errors;

  // Model: 0 = idle, 1 = running, 2 = burst finished
  int m_state;
  int m_k;      // pattern steps emitted so far in this run
  int m_last;   // index of the step now shown, -1 when lines are dark
  int m_mode;
  int m_burst;

  siren_pattern_sequencer #(.WIDTH(3), .CNT_W(8)) dut3 (
    .clock(clock), .reset(reset), .tick_enable(tick_enable),
    .enable_siren(enable_siren), .mode(mode), .burst_len(burst_len),
    .siren(siren3), .active(active3), .done(done3)
  );

  siren_pattern_sequencer #(.WIDTH(5), .CNT_W(8)) dut5 (
    .clock(clock), .reset(reset), .tick_enable(tick_enable),
    .enable_siren(enable_siren), .mode(mode), .burst_len(burst_len),
    .siren(siren5), .active(active5), .done(done5)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Line image of step k of a pattern on n lines, straight from the pattern rules.
  function automatic logic [15:0] exp_pat(int md, int k, int n);
    int per;
    int p;
    logic [15:0] r;
    case (md)
      0: r = (k % 2 == 0) ? 16'd1 : (16'd1 << (n - 1));
      1: r = 16'd1 << (k % n);
      2: begin
        per = 2 * n - 2;
        p = k % per;
        r = (p < n) ? (16'd1 << p) : (16'd1 << (per - p));
      end
      default: r = (k % 2 == 0) ? ((16'd1 << n) - 16'd1) : 16'd0;
    endcase
    return r;
  endfunction

  function automatic logic [15:0] exp_siren(int n);
    if (m_last < 0) return 16'd0;
    return exp_pat(m_mode, m_last, n);
  endfunction

  function automatic logic [4:0] exp_vec3();
    logic [15:0] s;
    s = exp_siren(3);
    return {s[2:0], m_state == 1, m_state == 2};
  endfunction

  function automatic logic [6:0] exp_vec5();
    logic [15:0] s;
    s = exp_siren(5);
    return {s[4:0], m_state == 1, m_state == 2};
  endfunction

  // One clock: inputs set at the falling edge, model advanced at the rising edge.
  task automatic cycle(input logic tk);
    tick_enable = tk;
    @(posedge clock);
    case (m_state)
      0: if (enable_siren) begin
        m_state = 1; m_mode = int'(mode); m_burst = int'(burst_len);
        m_k = 0; m_last = -1;
      end
      1: if (!enable_siren) begin
        m_state = 0; m_last = -1;
      end else if (tk) begin
        if (m_burst != 0 && m_k == m_burst) begin
          m_state = 2; m_last = -1;
        end else begin
          m_last = m_k; m_k = m_k + 1;
        end
      end
      default: if (!enable_siren) m_state = 0;
    endcase
    #1;
    @(negedge clock);
    tick_enable = 1'b0;
  endtask

  task automatic model_reset();
    m_state = 0; m_k = 0; m_last = -1; m_mode = 0; m_burst = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0; enable_siren = 1'b0; tick_enable = 1'b0; mode = 2'd0; burst_len = 8'd0;
    model_reset();
    repeat (3) @(negedge clock);
    checks++;
    if ({siren3, active3, done3, siren5, active5, done5} !== 12'd0) begin
      errors++;
      $display("FAIL reset_init got=%b%b%b/%b%b%b exp=all zero", siren3, active3, done3, siren5, active5, done5);
    end
    reset = 1'b1;
    enable_siren = 1'b1;
    cycle(1'b0);
    cycle(1'b1);
    cycle(1'b1);
    // asynchronous reset between edges while running
    #2 reset = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({siren3, active3, done3, siren5, active5, done5} !== 12'd0) begin
      errors++;
      $display("FAIL reset_async got=%b%b%b/%b%b%b exp=all zero", siren3, active3, done3, siren5, active5, done5);
    end
    @(negedge clock);
    reset = 1'b1;
    cycle(1'b0);
    checks++;
    if ({siren3, active3, done3} !== 5'b000_1_0) begin
      errors++;
      $display("FAIL reset_restart got=%b%b%b exp=00010", siren3, active3, done3);
    end
    cycle(1'b1);
    checks++;
    if ({siren3, active3} !== 4'b001_1) begin
      errors++;
      $display("FAIL reset_first_step got=%b%b exp=0011", siren3, active3);
    end
  endtask

  task automatic test_alternate();
    logic [2:0] want;
    enable_siren = 1'b0;
    cycle(1'b0);
    mode = 2'd0; burst_len = 8'd0; enable_siren = 1'b1;
    cycle(1'b0);
    for (int t = 1; t <= 20; t++) begin
      for (int c = 0; c < 4; c++) begin
        cycle(c == 3);
        checks++;
        if ({siren3, active3, done3} !== exp_vec3() || {siren5, active5, done5} !== exp_vec5()) begin
          errors++;
          $display("FAIL alt_model tick=%0d got=%b%b%b/%b%b%b exp=%b/%b", t, siren3, active3, done3,
                   siren5, active5, done5, exp_vec3(), exp_vec5());
        end
      end
      want = (t % 2 == 1) ? 3'b001 : 3'b100;
      checks++;
      if (siren3 !== want || active3 !== 1'b1 || done3 !== 1'b0) begin
        errors++;
        $display("FAIL alt_const tick=%0d got=%b a=%b d=%b exp=%b a=1 d=0", t, siren3, active3, done3, want);
      end
    end
  endtask

  task automatic test_chase_bounce();
    logic [2:0] chase3[8]  = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
    logic [2:0] bounce3[8] = '{3'b001, 3'b010, 3'b100, 3'b010, 3'b001, 3'b010, 3'b100, 3'b010};
    logic [4:0] want5;
    for (int md = 1; md <= 2; md++) begin
      enable_siren = 1'b0;
      cycle(1'b0);
      mode = 2'(md); burst_len = 8'd0; enable_siren = 1'b1;
      cycle(1'b0);
      for (int t = 0; t < 8; t++) begin
        cycle(1'b1);
        checks++;
        if (siren3 !== ((md == 1) ? chase3[t] : bounce3[t])) begin
          errors++;
          $display("FAIL pat3 mode=%0d tick=%0d got=%b exp=%b", md, t + 1, siren3,
                   (md == 1) ? chase3[t] : bounce3[t]);
        end
        if (md == 1) begin
          want5 = 5'd1 << (t % 5);
          checks++;
          if (siren5 !== want5) begin
            errors++;
            $display("FAIL chase5 tick=%0d got=%b exp=%b", t + 1, siren5, want5);
          end
        end
        checks++;
        if ({siren5, active5, done5} !== exp_vec5()) begin
          errors++;
          $display("FAIL pat5_model mode=%0d tick=%0d got=%b%b%b exp=%b", md, t + 1, siren5, active5, done5, exp_vec5());
        end
      end
    end
  endtask

  task automatic test_flash_burst();
    logic [2:0] s_tbl[5] = '{3'b111, 3'b000, 3'b111, 3'b000, 3'b000};
    logic       a_tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       d_tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    enable_siren = 1'b0;
    cycle(1'b0);
    mode = 2'd3; burst_len = 8'd3; enable_siren = 1'b1;
    cycle(1'b0);
    for (int t = 0; t < 5; t++) begin
      cycle(1'b1);
      cycle(1'b0);
      checks++;
      if (siren3 !== s_tbl[t] || active3 !== a_tbl[t] || done3 !== d_tbl[t]) begin
        errors++;
        $display("FAIL flash tick=%0d got=%b a=%b d=%b exp=%b a=%b d=%b", t + 1, siren3, active3, done3,
                 s_tbl[t], a_tbl[t], d_tbl[t]);
      end
      checks++;
      if ({siren5, active5, done5} !== exp_vec5()) begin
        errors++;
        $display("FAIL flash5 tick=%0d got=%b%b%b exp=%b", t + 1, siren5, active5, done5, exp_vec5());
      end
    end
    enable_siren = 1'b0;
    cycle(1'b0);
    checks++;
    if (done3 !== 1'b0 || active3 !== 1'b0 || done5 !== 1'b0) begin
      errors++;
      $display("FAIL flash_release got d=%b a=%b d5=%b exp=0 0 0", done3, active3, done5);
    end
    enable_siren = 1'b1;
    cycle(1'b0);
    cycle(1'b1);
    checks++;
    if (siren3 !== 3'b111 || active3 !== 1'b1) begin
      errors++;
      $display("FAIL flash_rearm got=%b a=%b exp=111 a=1", siren3, active3);
    end
  endtask

  task automatic test_mid_events();
    enable_siren = 1'b0;
    cycle(1'b0);
    mode = 2'd0; burst_len = 8'd0; enable_siren = 1'b1;
    cycle(1'b0);
    cycle(1'b1);
    mode = 2'd1; burst_len = 8'd1;
    cycle(1'b1);
    checks++;
    if (siren3 !== 3'b100) begin
      errors++;
      $display("FAIL mode_change got=%b exp=100", siren3);
    end
    cycle(1'b1);
    cycle(1'b1);
    checks++;
    if (siren3 !== 3'b100 || active3 !== 1'b1) begin
      errors++;
      $display("FAIL burst_change got=%b a=%b exp=100 a=1", siren3, active3);
    end
    enable_siren = 1'b0;
    cycle(1'b1);
    checks++;
    if (siren3 !== 3'b000 || active3 !== 1'b0 || siren5 !== 5'b0) begin
      errors++;
      $display("FAIL stop_with_tick got=%b a=%b s5=%b exp=000 a=0 s5=0", siren3, active3, siren5);
    end
    burst_len = 8'd0;
    enable_siren = 1'b1;
    cycle(1'b1);
    checks++;
    if (siren3 !== 3'b000 || active3 !== 1'b1) begin
      errors++;
      $display("FAIL start_with_tick got=%b a=%b exp=000 a=1", siren3, active3);
    end
    cycle(1'b0);
    checks++;
    if (siren3 !== 3'b000) begin
      errors++;
      $display("FAIL start_hold got=%b exp=000", siren3);
    end
    cycle(1'b1);
    checks++;
    if (siren3 !== 3'b001 || {siren5, active5, done5} !== exp_vec5()) begin
      errors++;
      $display("FAIL start_first got=%b s5=%b exp=001 s5=%b", siren3, siren5, exp_vec5());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 24) == 0) enable_siren = ~enable_siren;
      mode = 2'($urandom_range(0, 3));
      burst_len = 8'($urandom_range(0, 6));
      cycle($urandom_range(0, 2) == 0);
      checks++;
      if ({siren3, active3, done3} !== exp_vec3() || {siren5, active5, done5} !== exp_vec5()) begin
        errors++;
        $display("FAIL random cyc=%0d got=%b%b%b/%b%b%b exp=%b/%b", i, siren3, active3, done3,
                 siren5, active5, done5, exp_vec3(), exp_vec5());
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_alternate();
    test_chase_bounce();
    test_flash_burst();
    test_mid_events();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/siren_pattern_sequencer.md
Name: siren_pattern_sequencer

Overview:
- Parametrised successor to the two-phase siren driver in the anti-theft system.
- Drives WIDTH siren/lamp lines in one of four selectable patterns. Advances one step per external tick-enable pulse.
- Supports an optional burst length, after which it stops and flags completion.
- Sits between the alarm FSM (enable_siren, mode, burst_len) and the lamp/buzzer outputs; tick_enable comes from the shared divider (e.g. 2 Hz).

Parameters:
WIDTH, 3, number of siren output lines (legal range 2..16)
CNT_W, 8, width of burst_len and internal step counter

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
tick_enable  input  1  single-clock step pulse from the divider
enable_siren  input  1  level; 1 = run the sequence, 0 = stop/clear
mode  input  2  pattern select; sampled only on start
burst_len  input  CNT_W  number of steps to emit; 0 = continuous; sampled only on start
siren  output  WIDTH  pattern output, registered
active  output  1  1 while in RUN
done  output  1  1 in DONE (burst finished)

Behaviour:
- Reset (reset=0, asynchronous): siren=0, active=0, done=0, state=IDLE; phase, step counter and latched mode/burst cleared. Effect is immediate, with no clock edge needed.
- States: IDLE, RUN, DONE. All outputs are registered; active=(state==RUN), done=(state==DONE).
- IDLE: siren=0.
  - enable_siren=1 at a clock edge: go to RUN; latch mode and burst_len; phase=0; step=0; siren stays 0.
  - Any tick_enable on that same edge is ignored.
- RUN, on a clock edge with enable_siren=0: go to IDLE, siren=0. This has priority over a coincident tick.
- RUN, on a tick_enable edge:
  - Burst end: if latched burst_len!=0 and step==burst_len, go to DONE and set siren=0.
  - Otherwise: siren<=pattern(mode,phase); phase advances (wrap at the pattern period); step<=step+1.
  - The step counter saturates at all-ones. It is not used when burst_len=0.
- RUN, no tick: siren holds its value.
- DONE: siren=0, done=1, held until enable_siren=0, then IDLE on the next edge. Re-arming requires enable_siren to go low then high.
- Changes to mode and burst_len during RUN or DONE are ignored.
- Patterns (bit 0 = LSB, N=WIDTH):
  - mode 0 ALTERNATE, period 2: step 0 = bit 0 only; step 1 = bit N-1 only. For N=3 this gives 001, 100.
  - mode 1 CHASE, period N: one-hot rotating from bit 0 up to bit N-1, then wrapping.
  - mode 2 BOUNCE, period 2N-2: one-hot 0,1,…,N-1,N-2,…,1. For N=2 this is identical to CHASE.
  - mode 3 FLASH, period 2: all ones, then all zeros.
- Phase counter width: ceil(log2(2N)).
  - Phase resets to 0 only on start or reset.
  - Pattern wrap is exact: there is no skipped or repeated step at the wrap boundary.
- burst_len=K≠0: exactly K pattern steps are emitted, then siren=0 on tick K+1 with the DONE transition.

Test Plan:
1. Reset: drive reset=0 mid-RUN between clock edges → siren=000, active=0, done=0 immediately. Release reset, raise enable → sequence restarts from step 0.
2. ALTERNATE, WIDTH=3, burst_len=0, enable=1, tick every 4 clocks:
   - siren=000 until the first tick, then 001, 100, 001, 100 for 20 ticks.
   - active=1 throughout; done never asserts.
3. CHASE and BOUNCE, WIDTH=3, 8 ticks:
   - CHASE → 001, 010, 100, 001, 010, 100, 001, 010.
   - BOUNCE → 001, 010, 100, 010, 001, 010, 100, 010.
   - Repeat CHASE with WIDTH=5 → 00001 … 10000, then 00001.
4. FLASH burst, burst_len=3, 5 ticks:
   - Ticks 1–3 → 111, 000, 111.
   - Tick 4 → siren=000, done=1, active=0.
   - Tick 5 → no change.
   - Drop enable → done=0 the next clock.
   - Raise enable again → new burst starts.
5. Mid-operation events:
   - Change mode 0→1 during RUN → pattern unchanged.
   - Assert tick_enable in the same cycle that enable_siren falls → siren=000 and IDLE on that edge.
   - Assert enable_siren and tick_enable on the same edge from IDLE → siren stays 000 until the next tick.
